// File: rtl/result_unloader_if.sv
// Host-side bundle of the result unloader: capture strobe plus the four array
// results going in, and the byte stream with status flags coming out.
interface result_unloader_if #(
  parameter int DATA_W = 8
);
  logic              capture;
  logic [DATA_W-1:0] c00;
  logic [DATA_W-1:0] c01;
  logic [DATA_W-1:0] c10;
  logic [DATA_W-1:0] c11;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;
  logic              busy;
  logic              overrun;
  logic              clear_overrun;

  // Feeder/host side: drives captures and the ready handshake.
  modport master (
    output capture, c00, c01, c10, c11, out_ready, clear_overrun,
    input  out_data, out_valid, out_last, busy, overrun
  );

  // Unloader side.
  modport slave (
    input  capture, c00, c01, c10, c11, out_ready, clear_overrun,
    output out_data, out_valid, out_last, busy, overrun
  );
endinterface

// File: rtl/result_unloader.sv
// Double-buffered result unloader: captures a 2x2 result set in one cycle and
// streams it out one byte per accepted transfer, with one pending set held
// behind the active one so the array can restart while the host still reads.
module result_unloader #(
  parameter int DATA_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  result_unloader_if.slave bus
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_e;

  // Element 0 is c00 and is streamed first; element 3 is c11 and is last.
  typedef logic [3:0][DATA_W-1:0] set_t;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic              pend_q, pend_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  set_t              a_q, a_d;
  set_t              p_q, p_d;
  set_t              cap_set;
  logic              xfer;
  logic              last_xfer;
  logic              drop;

  assign cap_set   = {bus.c11, bus.c10, bus.c01, bus.c00};
  assign xfer      = (state_q == S_DRAIN) && bus.out_ready;
  assign last_xfer = xfer && (idx_q == 2'd3);

  // Next-state: buffer movement, drain index and drop detection.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    a_d     = a_q;
    p_d     = p_q;
    drop    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.capture) begin
          a_d     = cap_set;
          idx_d   = 2'd0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_xfer) begin
          idx_d = 2'd0;
          if (bus.capture) begin
            // Last byte leaves while a new set arrives: no bubble, no overrun.
            if (pend_q) begin
              a_d = p_q;
              p_d = cap_set;
            end else begin
              a_d = cap_set;
            end
          end else if (pend_q) begin
            a_d    = p_q;
            pend_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          if (xfer) begin
            idx_d = idx_q + 2'd1;
          end
          if (bus.capture) begin
            if (!pend_q) begin
              p_d    = cap_set;
              pend_d = 1'b1;
            end else begin
              drop = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered output byte and flags, derived from the next buffer position.
  always_comb begin
    out_data_d = (state_d == S_DRAIN) ? a_d[idx_d] : '0;
    out_last_d = (state_d == S_DRAIN) && (idx_d == 2'd3);
    // A drop in the same cycle as a clear keeps the flag set.
    overrun_d  = drop ? 1'b1 : (bus.clear_overrun ? 1'b0 : overrun_q);
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      pend_q     <= 1'b0;
      overrun_q  <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its pre-edge value regardless of statement order.
      state_q    <= state_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      overrun_q  <= overrun_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  end

  // Result buffers.
  always_ff @(posedge clk) begin
    // NOTE: the buffers carry no reset; their contents are only observable
    // through the reset-cleared state and out_data registers.
    a_q <= a_d;
    p_q <= p_d;
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = (state_q == S_DRAIN);
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state_q == S_DRAIN) || pend_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: doc/result_unloader.md
# result_unloader

Output-side buffer between the 2x2 systolic array's result registers and the host byte port. It captures all four 8-bit results in a single cycle when the feeder signals completion, and holds up to two result sets (active plus pending). It then streams the active set one byte per accepted transfer over a valid/ready handshake, so the array can be cleared and restarted while the host is still reading.

## Interface
- DATA_W, 8, width of each result element and of the output byte

- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- capture  input  1  one-cycle pulse: c00..c11 are final this cycle
- c00, c01, c10, c11  input  DATA_W each  array results
- out_data  output  DATA_W  current byte offered to host
- out_valid  output  1  out_data is valid
- out_last  output  1  high with the 4th byte (c11) of a set
- out_ready  input  1  host accepts out_data this cycle
- busy  output  1  active or pending buffer occupied
- overrun  output  1  sticky: a capture was dropped
- clear_overrun  input  1  synchronous clear of overrun

## Operation
- Storage:
  - Active buffer A[0..3] with occupancy flag.
  - Pending buffer P[0..3] with flag pend_full.
  - 2-bit drain index idx.
- Element order is fixed: 0=c00, 1=c01, 2=c10, 3=c11.
- States:
  - IDLE: A empty, out_valid=0.
  - DRAIN: A full, out_valid=1.
- A transfer occurs when out_valid && out_ready. Each transfer increments idx.
- Transfer with idx==3 (last byte):
  - If pend_full: P→A, idx=0, pend_full=0, stay DRAIN.
  - Else: IDLE.
- Capture in IDLE: load A, idx=0, go to DRAIN.
- Capture in DRAIN, not last-byte transfer:
  - If !pend_full: load P, pend_full=1.
  - Else: drop the data, set overrun=1. A, P and idx are unchanged.
- Capture coincident with last-byte transfer:
  - pend_full=0: capture loads directly into A, idx=0, stay DRAIN. No bubble.
  - pend_full=1: P→A and capture→P, pend_full stays 1. No overrun.
- out_data=A[idx], out_last=(idx==3) && out_valid.
- out_data and out_last are registered; out_data holds its value while out_valid=1 && out_ready=0.
- busy = out_valid || pend_full.
- overrun:
  - Sticky.
  - Cleared by clear_overrun.
  - If a drop and clear_overrun occur in the same cycle, set wins.
- No arithmetic: bytes pass unmodified.
- out_ready while out_valid=0 is ignored.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - out_valid=0, out_last=0, out_data=0, overrun=0, busy=0.
  - idx=0, pend_full=0, state IDLE.
- Release is synchronous to the next clk edge.
- Capture latency: capture at edge t from IDLE → out_valid=1, out_data=c00 after edge t (visible in cycle t+1).
- Throughput: with out_ready held high, one byte per cycle.
  - Back-to-back sets stream with no idle cycle.
- Minimum drain is 4 cycles per set.
- Sustained capture spacing ≥4 cycles never overruns when out_ready=1.
- Reset mid-drain discards both buffers. out_valid drops immediately (asynchronous).

## Test plan
- Reset, then capture with {c00..c11}={0x11,0x22,0x33,0x44}, out_ready=1 → out_data sequence 0x11,0x22,0x33,0x44 on cycles t+1..t+4, out_last only with 0x44, then out_valid=0.
- Same capture with out_ready toggled 1,0,0,1,1,0,1 → each byte held stable while stalled, exactly 4 transfers, order preserved.
- Capture set A=0x01..0x04, second capture B=0x05..0x08 two cycles later with out_ready=1 → 8 contiguous valid bytes 0x01..0x08, out_valid never deasserts between sets, overrun=0.
- out_ready=0, three captures (0xA*, 0xB*, 0xC*) → overrun=1, busy=1, drained bytes are the 0xA* then 0xB* sets only; assert clear_overrun → overrun=0 next cycle.
- Capture coincident with last-byte transfer of the previous set (pend empty) → next cycle out_data=new c00, no out_valid gap; repeat with pend_full=1 → pending set drained next, new set drained after it, overrun stays 0.
- Assert rst_n=0 mid-drain at idx=2 → out_valid=0, out_data=0, busy=0 without waiting for clk; after release, no residual bytes are emitted.
